// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard sequencer: FSM encoding,
// stage-register indices and the bubble width.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd2;
    localparam logic [1:0] ST_ABORT      = 2'd3;

    typedef enum logic [1:0] {
        RUN        = ST_RUN,
        LOAD_STALL = ST_LOAD_STALL,
        MEM_WAIT   = ST_MEM_WAIT,
        ABORT      = ST_ABORT
    } hz_state_t;

    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;
    localparam int NUM_STAGES = 4;

    // A bubble is an all-zero stage register of this width.
    localparam int BUBBLE_W = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard term: a load in EX writes a register that
// the ID instruction reads. r0 never hazards.
module load_use_detect #(
    parameter int RegAddrBits = 5
) (
    input  logic [RegAddrBits-1:0] i_id_rs,
    input  logic [RegAddrBits-1:0] i_id_rt,
    input  logic [RegAddrBits-1:0] i_ex_rd,
    input  logic                   i_ex_mem_to_reg,
    input  logic                   i_ex_reg_write,
    output logic                   o_hz
);

    logic w_match;

    assign w_match = (i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt);
    assign o_hz    = i_ex_mem_to_reg & i_ex_reg_write & (i_ex_rd != '0) & w_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID..MEM/WB register chain.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RegAddrBits     = 5,
    parameter int LoadStallCycles = 1,
    parameter int TimeoutCycles   = 255
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Tick,
    input  logic [RegAddrBits-1:0] id_rs,
    input  logic [RegAddrBits-1:0] id_rt,
    input  logic [RegAddrBits-1:0] ex_rd,
    input  logic                   ex_mem_to_reg,
    input  logic                   ex_reg_write,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    input  logic                   branch_taken,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_flush_cnt,
`endif
    output logic [1:0]             ctrl_state
);

    localparam logic [3:0]  STALL_LAST = 4'(LoadStallCycles - 1);
    localparam logic [15:0] WAIT_MAX   = 16'(TimeoutCycles);

    hz_state_t               r_state, w_nstate;
    logic [3:0]              r_stall_cnt, w_nstall;
    logic [15:0]             r_wait_cnt, w_nwait;
    logic                    r_timeout, w_set_to;
    logic                    w_hz, w_memstall, w_go, w_pc;
    logic                    w_fl_ifid, w_fl_idex;
    logic [NUM_STAGES-1:0]   w_en;

    load_use_detect #(.RegAddrBits(RegAddrBits)) u_hz (
        .i_id_rs         (id_rs),
        .i_id_rt         (id_rt),
        .i_ex_rd         (ex_rd),
        .i_ex_mem_to_reg (ex_mem_to_reg),
        .i_ex_reg_write  (ex_reg_write),
        .o_hz            (w_hz)
    );

    assign w_memstall = mem_req & ~mem_ack;

    always_comb begin
        w_nstate  = r_state;
        w_nstall  = r_stall_cnt;
        w_nwait   = r_wait_cnt;
        w_set_to  = 1'b0;
        w_pc      = 1'b0;
        w_en      = '0;
        w_fl_ifid = 1'b0;
        w_fl_idex = 1'b0;
        case (r_state)
            RUN, LOAD_STALL: begin
                if (w_memstall) begin
                    w_nstate = MEM_WAIT;
                    w_nwait  = 16'd1;
                    w_nstall = '0;
                end else if (r_state == RUN && branch_taken) begin
                    w_pc      = 1'b1;
                    w_en      = '1;
                    w_fl_ifid = 1'b1;
                    w_fl_idex = 1'b1;
                end else if (r_state == LOAD_STALL || w_hz) begin
                    // Hold IF/ID and the PC, push a bubble into ID/EX.
                    w_en[STG_ID_EX]  = 1'b1;
                    w_en[STG_EX_MEM] = 1'b1;
                    w_en[STG_MEM_WB] = 1'b1;
                    w_fl_idex        = 1'b1;
                    if (r_state == RUN) begin
                        if (LoadStallCycles > 1) begin
                            w_nstate = LOAD_STALL;
                            w_nstall = 4'd1;
                        end
                    end else if (r_stall_cnt >= STALL_LAST) begin
                        w_nstate = RUN;
                        w_nstall = '0;
                    end else begin
                        w_nstall = r_stall_cnt + 4'd1;
                    end
                end else begin
                    w_pc = 1'b1;
                    w_en = '1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    w_pc     = 1'b1;
                    w_en     = '1;
                    w_nstate = RUN;
                    w_nwait  = '0;
                end else if (r_wait_cnt >= WAIT_MAX - 16'd1) begin
                    w_nwait  = WAIT_MAX;
                    w_set_to = 1'b1;
                    w_nstate = ABORT;
                end else begin
                    w_nwait = r_wait_cnt + 16'd1;
                end
            end
            ABORT: begin
                w_pc     = 1'b1;
                w_en     = '1;
                w_en[STG_MEM_WB] = 1'b0;
                w_nstate = RUN;
                w_nwait  = '0;
            end
            default: w_nstate = RUN;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else if (Tick) begin
            r_state     <= w_nstate;
            r_stall_cnt <= w_nstall;
            r_wait_cnt  <= w_nwait;
            r_timeout   <= r_timeout | w_set_to;
        end
    end

    assign w_go        = Tick & ~Reset;
    assign pc_en       = w_go & w_pc;
    assign if_id_en    = w_go & w_en[STG_IF_ID];
    assign id_ex_en    = w_go & w_en[STG_ID_EX];
    assign ex_mem_en   = w_go & w_en[STG_EX_MEM];
    assign mem_wb_en   = w_go & w_en[STG_MEM_WB];
    assign if_id_flush = w_go & w_fl_ifid;
    assign id_ex_flush = w_go & w_fl_idex;
    assign mem_timeout = r_timeout;
    assign ctrl_state  = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall, r_perf_flush;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else if (Tick) begin
            if (!w_pc)     r_perf_stall <= r_perf_stall + 32'd1;
            if (w_fl_ifid) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: two configurations checked
// against a remaining-bubbles / wait-length model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       Reset, Tick;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       ex_mem_to_reg, ex_reg_write, mem_req, mem_ack, branch_taken;
    logic [1:0] pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic [1:0] if_id_flush, id_ex_flush, mem_timeout;
    logic [1:0] cs0, cs1;

    pipeline_hazard_ctrl #(.RegAddrBits(5), .LoadStallCycles(1), .TimeoutCycles(4)) u0 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .mem_req(mem_req),
        .mem_ack(mem_ack), .branch_taken(branch_taken), .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
        .id_ex_en(id_ex_en[0]), .ex_mem_en(ex_mem_en[0]), .mem_wb_en(mem_wb_en[0]),
        .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]), .mem_timeout(mem_timeout[0]),
        .ctrl_state(cs0));

    pipeline_hazard_ctrl #(.RegAddrBits(5), .LoadStallCycles(3), .TimeoutCycles(6)) u1 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .mem_req(mem_req),
        .mem_ack(mem_ack), .branch_taken(branch_taken), .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
        .id_ex_en(id_ex_en[1]), .ex_mem_en(ex_mem_en[1]), .mem_wb_en(mem_wb_en[1]),
        .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]), .mem_timeout(mem_timeout[1]),
        .ctrl_state(cs1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: bubbles still owed, length of the current memory wait, abort pending.
    int m_stall[2], m_wait[2];
    bit m_abort[2], m_to[2];
    int LSC[2] = '{1, 3};
    int TCY[2] = '{4, 6};

    function automatic logic [9:0] obs(int k);
        logic [1:0] st;
        st = (k == 0) ? cs0 : cs1;
        return {pc_en[k], if_id_en[k], id_ex_en[k], ex_mem_en[k], mem_wb_en[k],
                if_id_flush[k], id_ex_flush[k], mem_timeout[k], st};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_wait[k] = 0; m_abort[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic step(input string tag);
        int  ns[2], nw[2];
        bit  na[2], nt[2];
        bit  hz, ms;
        logic [4:0] en;
        logic [1:0] fl;
        int  st;
        #1;
        if (Reset) model_reset();
        hz = ex_mem_to_reg && ex_reg_write && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        ms = mem_req && !mem_ack;
        for (int k = 0; k < 2; k++) begin
            ns[k] = m_stall[k]; nw[k] = m_wait[k]; na[k] = m_abort[k]; nt[k] = m_to[k];
            en = 5'b0; fl = 2'b0;
            st = m_abort[k] ? 3 : (m_wait[k] > 0) ? 2 : (m_stall[k] > 0) ? 1 : 0;
            if (m_abort[k]) begin
                en = 5'b11110; na[k] = 0;
            end else if (m_wait[k] > 0) begin
                if (mem_ack) begin
                    en = 5'b11111; nw[k] = 0;
                end else begin
                    nw[k] = m_wait[k] + 1;
                    if (nw[k] >= TCY[k]) begin nt[k] = 1; na[k] = 1; nw[k] = 0; end
                end
            end else if (ms) begin
                nw[k] = 1; ns[k] = 0;
            end else if (m_stall[k] == 0 && branch_taken) begin
                en = 5'b11111; fl = 2'b11;
            end else if (m_stall[k] > 0 || hz) begin
                en = 5'b00111; fl = 2'b01;
                ns[k] = (m_stall[k] == 0) ? LSC[k] - 1 : m_stall[k] - 1;
            end else begin
                en = 5'b11111;
            end
            if (!Tick || Reset) begin en = 5'b0; fl = 2'b0; end
            chk($sformatf("%s_u%0d", tag, k), {22'b0, obs(k)},
                {22'b0, en, fl, m_to[k], 2'(st)});
        end
        @(posedge Clock);
        if (!Reset && Tick)
            for (int k = 0; k < 2; k++) begin
                m_stall[k] = ns[k]; m_wait[k] = nw[k]; m_abort[k] = na[k]; m_to[k] = nt[k];
            end
        #1;
    endtask

    task automatic idle_in();
        Tick = 1; id_rs = 5'd1; id_rt = 5'd2; ex_rd = 5'd3;
        ex_mem_to_reg = 0; ex_reg_write = 0; mem_req = 0; mem_ack = 0; branch_taken = 0;
    endtask

    initial begin
        Reset = 1; model_reset(); idle_in();
        step("reset");
        Reset = 0;
        step("run_idle");

        // load-use on r5
        ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs = 5'd5;
        #1; chk("hz_pc_en_u0", {31'b0, pc_en[0]}, 32'd0);
        chk("hz_idex_flush_u0", {31'b0, id_ex_flush[0]}, 32'd1);
        step("hz1");
        ex_mem_to_reg = 0;
        step("hz_after1"); step("hz_after2"); step("hz_after3");
        chk("hz_done_pc_u0", {31'b0, pc_en[0]}, 32'd1);

        // destination r0
        idle_in(); ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = 0; id_rs = 0;
        step("r0");

        // branch with hazard
        idle_in(); ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = 5'd7; id_rt = 5'd7; branch_taken = 1;
        step("br_hz"); idle_in(); step("br_after");

        // memory wait then ack
        mem_req = 1;
        repeat (3) step("mwait");
        mem_ack = 1; step("mack");
        mem_ack = 0; mem_req = 0; step("mdone");
        chk("mdone_state_u0", {30'b0, cs0}, 32'd0);

        // timeout
        mem_req = 1;
        repeat (4) step("tmo_wait");
        chk("tmo_state_u0", {30'b0, cs0}, 32'd3);
        chk("tmo_flag_u0", {31'b0, mem_timeout[0]}, 32'd1);
        step("tmo_abort");
        mem_req = 0;
        step("tmo_run");
        step("tmo_u1_cont"); step("tmo_u1_cont2");

        // reset during MEM_WAIT, then Tick low
        mem_req = 1; step("rst_pre1"); step("rst_pre2");
        Reset = 1; #1;
        chk("rst_state_u0", {30'b0, cs0}, 32'd0);
        chk("rst_to_u0", {31'b0, mem_timeout[0]}, 32'd0);
        step("rst_mid");
        Reset = 0; Tick = 0;
        repeat (3) step("tick0");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Reset         = ($urandom_range(0, 199) == 0);
            Tick          = ($urandom_range(0, 9) != 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_mem_to_reg = ($urandom_range(0, 1) == 1);
            ex_reg_write  = ($urandom_range(0, 3) != 0);
            mem_req       = ($urandom_range(0, 4) == 0) || (i % 400 > 380);
            mem_ack       = ($urandom_range(0, 2) == 0) && (i % 400 <= 380);
            branch_taken  = ($urandom_range(0, 6) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline register chain: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives the ClockEnable and synchronous-bubble (flush) inputs of every stage register.
- Detects load-use hazards on the EX MemToReg path, freezes the pipe during multi-cycle memory accesses, and squashes wrong-path instructions on taken branches.
- Sits beside the datapath; it only consumes register-file indices and control bits.

Parameters:
- RegAddrBits, 5, width of register indices.
- LoadStallCycles, 1, bubbles inserted per load-use hazard (1..15).
- TimeoutCycles, 255, maximum MEM_WAIT cycles before abort (1..65535).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Tick  in  1  global advance qualifier; state, counters and stage enables move only when Tick=1.
- id_rs  in  RegAddrBits  ID-stage source register 1.
- id_rt  in  RegAddrBits  ID-stage source register 2.
- ex_rd  in  RegAddrBits  EX-stage destination register.
- ex_mem_to_reg  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes the register file.
- mem_req  in  1  MEM stage has a memory access outstanding.
- mem_ack  in  1  memory completes the access this cycle.
- branch_taken  in  1  branch resolved taken in EX.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register ClockEnable.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all-zero) into the stage on the next edge.
- mem_timeout  out  1  sticky error; cleared only by Reset.
- ctrl_state  out  2  current FSM state encoding.

Behaviour:
- Reset values:
  - state is RUN.
  - All counters are 0.
  - mem_timeout is 0.
  - All enables and flushes are 0 while Reset is held.
- Hazard term: hz = ex_mem_to_reg & ex_reg_write & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt). This term is combinational.
- Outputs:
  - All outputs are combinational from the state and inputs (Mealy), with zero latency.
  - Every *_en output is ANDed with Tick.
  - Every *_flush output is ANDed with Tick.
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, ABORT=3.
- RUN, evaluated in priority order:
  1. If mem_req & ~mem_ack: all enables are 0 and no flush. Next state is MEM_WAIT, and the wait counter is set to 1.
  2. Else if branch_taken: all enables are 1, and if_id_flush and id_ex_flush are 1. The branch wins over hz because the hazarding ID instruction is squashed. Next state stays RUN.
  3. Else if hz: pc_en=0 and if_id_en=0; id_ex_en=1 and id_ex_flush=1; ex_mem_en=1 and mem_wb_en=1. If LoadStallCycles>1, next state is LOAD_STALL with the stall counter set to 1; otherwise next state stays RUN.
  4. Else: all enables are 1 and there is no flush.
- LOAD_STALL:
  - Outputs are the same as RUN case 3.
  - The stall counter increments each Tick.
  - When the counter reaches LoadStallCycles-1, the next state is RUN.
  - If mem_req & ~mem_ack arrives, MEM_WAIT takes precedence and the stall counter is discarded.
- MEM_WAIT:
  - All enables are 0.
  - On mem_ack: the same cycle behaves as RUN with no memory stall (enables 1). Next state is RUN.
  - Otherwise the wait counter increments. When it reaches TimeoutCycles, mem_timeout is set and the next state is ABORT.
  - A branch_taken seen while in MEM_WAIT is ignored; EX is frozen, so the branch is re-presented after the freeze.
- ABORT:
  - Same outputs as RUN case 4, except that mem_wb_en=0, which suppresses write-back of the failed access for one Tick.
  - Next state is RUN.
- Tick=0: state and counters hold, and all enables and flushes are 0.
- Counters:
  - Stall counter is 4 bits.
  - Wait counter is 16 bits and saturates at TimeoutCycles.
- Reset asserted in the middle of any state returns immediately to RUN. The hazard is re-evaluated from the first cycle after Reset is released.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds two 32-bit wrapping outputs, perf_stall_cnt and perf_flush_cnt, both reset to 0.
  - perf_stall_cnt increments on each Tick where pc_en=0.
  - perf_flush_cnt increments on each Tick where if_id_flush=1.
- When undefined: the ports and logic are absent.

Decomposition:
- Shared package holds:
  - the state encoding localparams (RUN, LOAD_STALL, MEM_WAIT, ABORT);
  - the stage-index constants;
  - the bubble width constant.
- One sub-module, load_use_detect: the combinational hz term, reusable by a future forwarding unit.

Test Plan:
- Load-use hazard: ex_mem_to_reg=1, ex_reg_write=1, ex_rd=5, id_rs=5, Tick=1, LoadStallCycles=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle, then all enables are 1.
- Destination r0: ex_rd=0 with id_rs=0 and a load in EX -> no stall; all enables are 1.
- Branch beats hazard: branch_taken=1 together with the hz condition -> if_id_flush=1, id_ex_flush=1, pc_en=1, and no stall state is entered.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then ack -> all enables are 0 for 3 cycles, 1 on the ack cycle, and ctrl_state returns to 0.
- Timeout: TimeoutCycles=4 and mem_ack is never asserted -> mem_timeout=1 after 4 wait cycles, ctrl_state=3 for 1 cycle with mem_wb_en=0, then state 0 with mem_timeout still 1.
- Reset mid-stall: assert Reset during MEM_WAIT -> ctrl_state=0 and mem_timeout=0 immediately; Tick=0 afterwards -> all enables are 0 and the state holds.
